// File: rtl/dcache_txn_tracker.sv
// -----------------------------------------------------------------------------
// dcache_txn_tracker
// Tracks in-flight transactions between core memory requests and the HPDC
// request port.
//   - A request is forwarded only when its tag is idle, the outstanding count
//     is below MAX_INFLIGHT and no fence is draining.
//   - Counts outstanding transactions.
//   - Flags (sticky) responses that arrive for tags with nothing outstanding.
//   - Fence: blocks new requests until every response has returned and the
//     write buffer is empty, then pulses fence_done_o for one cycle.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   req_valid_i       core request valid
//   req_tag_i         core request tag
//   req_ready_o       request accepted by the cache this cycle
//   req_valid_o       request valid towards the HPDC
//   cache_ready_i     HPDC request ready
//   rsp_valid_i       HPDC response valid
//   rsp_tag_i         HPDC response tag
//   wbuf_empty_i      HPDC write buffer empty
//   fence_i           fence request pulse
//   fence_busy_o      fence in progress
//   fence_done_o      one-cycle pulse when the fence completes
//   inflight_o        current outstanding count
//   stall_tag_o       request blocked by a busy tag
//   stall_full_o      request blocked by the outstanding limit
//   err_rsp_o         sticky: response arrived for an idle tag
// -----------------------------------------------------------------------------
module dcache_txn_tracker #(
   parameter int TAG_W        = 7,
   parameter int MAX_INFLIGHT = 16,
   parameter bit RSP_BYPASS   = 1'b0,
   localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             req_ready_o,
   output logic             req_valid_o,
   input  logic             cache_ready_i,
   input  logic             rsp_valid_i,
   input  logic [TAG_W-1:0] rsp_tag_i,
   input  logic             wbuf_empty_i,
   input  logic             fence_i,
   output logic             fence_busy_o,
   output logic             fence_done_o,
   output logic [CNT_W-1:0] inflight_o,
   output logic             stall_tag_o,
   output logic             stall_full_o,
   output logic             err_rsp_o
);

   localparam int NUM_TAGS = 1 << TAG_W;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [NUM_TAGS-1:0] busy;
   logic [CNT_W-1:0]    inflight;
   logic                err_rsp;

   logic                rsp_match;
   logic                tag_free;
   logic                full;
   logic                run;
   logic                gate;
   logic                send;
   logic                recv;

   // Request gating: tag availability, outstanding limit and fence state
   always_comb begin
      // A response retiring the very tag being requested frees it in the same
      // cycle only when the bypass is built in.
      rsp_match = rsp_valid_i & (rsp_tag_i == req_tag_i) & busy[rsp_tag_i];
      if (RSP_BYPASS) begin
         tag_free = ~busy[req_tag_i] | rsp_match;
      end else begin
         tag_free = ~busy[req_tag_i];
      end
      full         = (inflight == CNT_W'(MAX_INFLIGHT));
      gate         = tag_free & ~full & run;
      req_valid_o  = req_valid_i & gate;
      req_ready_o  = cache_ready_i & gate;
      send         = req_valid_i & gate & cache_ready_i;
      recv         = rsp_valid_i & busy[rsp_tag_i];
      stall_tag_o  = req_valid_i & ~tag_free;
      // When the tag is free and the limit not reached, full is 0, so this
      // reduces to the plain "valid and full" term.
      stall_full_o = req_valid_i & full;
   end

   // Tag table: a response clears its tag, a send sets its tag (set wins)
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy <= {NUM_TAGS{1'b0}};
      end else begin
         if (recv) begin
            busy[rsp_tag_i] <= 1'b0;
         end
         if (send) begin
            busy[req_tag_i] <= 1'b1;
         end
      end
   end

   // Outstanding counter; full gates send and recv needs a busy tag, so it
   // can neither overflow nor underflow
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         inflight <= {CNT_W{1'b0}};
      end else begin
         case ({send, recv})
            2'b10:   inflight <= inflight + CNT_W'(1);
            2'b01:   inflight <= inflight - CNT_W'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // Sticky error for responses to idle tags
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_rsp <= 1'b0;
      end else if (rsp_valid_i & ~busy[rsp_tag_i]) begin
         err_rsp <= 1'b1;
      end else begin
         err_rsp <= err_rsp;
      end
   end

   // Fence FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Fence FSM next-state logic
   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (fence_i) begin
               state_next = DRAIN;
            end else begin
               state_next = RUN;
            end
         end
         DRAIN: begin
            // A response landing this cycle is still being retired; wait one
            // more cycle so the counter has settled.
            if ((inflight == {CNT_W{1'b0}}) & wbuf_empty_i & ~recv) begin
               state_next = DONE;
            end else begin
               state_next = DRAIN;
            end
         end
         DONE:    state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // Fence FSM outputs
   always_comb begin
      run          = 1'b0;
      fence_busy_o = 1'b1;
      fence_done_o = 1'b0;
      case (state)
         RUN: begin
            run          = 1'b1;
            fence_busy_o = 1'b0;
         end
         DRAIN: begin
            fence_busy_o = 1'b1;
         end
         DONE: begin
            fence_done_o = 1'b1;
         end
         default: begin
            run          = 1'b0;
            fence_busy_o = 1'b1;
            fence_done_o = 1'b0;
         end
      endcase
   end

   assign inflight_o = inflight;
   assign err_rsp_o  = err_rsp;

endmodule

// File: tb/tb_dcache_txn_tracker.sv
// -----------------------------------------------------------------------------
// tb_dcache_txn_tracker
// Two tracker instances share one stimulus stream:
//   dut_a: MAX_INFLIGHT=4,  RSP_BYPASS=1
//   dut_b: MAX_INFLIGHT=16, RSP_BYPASS=0
// A reference model keeps the set of outstanding tags per instance; the
// outstanding count is the population of that set.
// -----------------------------------------------------------------------------
module tb_dcache_txn_tracker;

   localparam int TAG_W = 7;
   localparam int NT    = 1 << TAG_W;
   localparam int MAX_A = 4;
   localparam int MAX_B = 16;
   localparam int CW_A  = $clog2(MAX_A + 1);
   localparam int CW_B  = $clog2(MAX_B + 1);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             cache_ready = 1'b0;
   logic             rsp_valid = 1'b0;
   logic [TAG_W-1:0] rsp_tag = '0;
   logic             wbuf_empty = 1'b0;
   logic             fence = 1'b0;

   logic            a_req_ready, a_req_valid, a_fence_busy, a_fence_done;
   logic            a_stall_tag, a_stall_full, a_err;
   logic [CW_A-1:0] a_inflight;
   logic            b_req_ready, b_req_valid, b_fence_busy, b_fence_done;
   logic            b_stall_tag, b_stall_full, b_err;
   logic [CW_B-1:0] b_inflight;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state: index 0 = dut_a, 1 = dut_b
   bit mbusy [2][NT];
   int mstate[2];          // 0 running, 1 draining, 2 fence done
   bit merr  [2];
   int mmax  [2] = '{MAX_A, MAX_B};
   bit mbyp  [2] = '{1'b1, 1'b0};

   dcache_txn_tracker #(.TAG_W(TAG_W), .MAX_INFLIGHT(MAX_A), .RSP_BYPASS(1'b1)) dut_a (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_tag_i(req_tag),
      .req_ready_o(a_req_ready), .req_valid_o(a_req_valid),
      .cache_ready_i(cache_ready),
      .rsp_valid_i(rsp_valid), .rsp_tag_i(rsp_tag),
      .wbuf_empty_i(wbuf_empty), .fence_i(fence),
      .fence_busy_o(a_fence_busy), .fence_done_o(a_fence_done),
      .inflight_o(a_inflight),
      .stall_tag_o(a_stall_tag), .stall_full_o(a_stall_full),
      .err_rsp_o(a_err)
   );

   dcache_txn_tracker #(.TAG_W(TAG_W), .MAX_INFLIGHT(MAX_B), .RSP_BYPASS(1'b0)) dut_b (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_tag_i(req_tag),
      .req_ready_o(b_req_ready), .req_valid_o(b_req_valid),
      .cache_ready_i(cache_ready),
      .rsp_valid_i(rsp_valid), .rsp_tag_i(rsp_tag),
      .wbuf_empty_i(wbuf_empty), .fence_i(fence),
      .fence_busy_o(b_fence_busy), .fence_done_o(b_fence_done),
      .inflight_o(b_inflight),
      .stall_tag_o(b_stall_tag), .stall_full_o(b_stall_full),
      .err_rsp_o(b_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic int mcount(input int k);
      int c = 0;
      for (int i = 0; i < NT; i++) c += int'(mbusy[k][i]);
      return c;
   endfunction

   // model view of the gating rules for instance k under the current inputs
   task automatic model_gate(input int k, output bit tf, output bit fl, output bit gt);
      tf = !mbusy[k][req_tag] ||
           (mbyp[k] && rsp_valid && (rsp_tag == req_tag) && mbusy[k][rsp_tag]);
      fl = (mcount(k) == mmax[k]);
      gt = tf && !fl && (mstate[k] == 0);
   endtask

   task automatic check_outputs();
      for (int k = 0; k < 2; k++) begin
         bit tf, fl, gt;
         string p;
         int rv, rr, sti, sfu, fb, fd, inf, er;
         model_gate(k, tf, fl, gt);
         if (k == 0) begin
            p = "a"; rv = a_req_valid; rr = a_req_ready; sti = a_stall_tag; sfu = a_stall_full;
            fb = a_fence_busy; fd = a_fence_done; inf = int'(a_inflight); er = a_err;
         end else begin
            p = "b"; rv = b_req_valid; rr = b_req_ready; sti = b_stall_tag; sfu = b_stall_full;
            fb = b_fence_busy; fd = b_fence_done; inf = int'(b_inflight); er = b_err;
         end
         check({p, ".req_valid_o"},  rv,  int'(req_valid && gt));
         check({p, ".req_ready_o"},  rr,  int'(cache_ready && gt));
         check({p, ".stall_tag_o"},  sti, int'(req_valid && !tf));
         check({p, ".stall_full_o"}, sfu, int'(req_valid && fl));
         check({p, ".fence_busy_o"}, fb,  int'(mstate[k] != 0));
         check({p, ".fence_done_o"}, fd,  int'(mstate[k] == 2));
         check({p, ".inflight_o"},   inf, mcount(k));
         check({p, ".err_rsp_o"},    er,  int'(merr[k]));
      end
   endtask

   // advance the model by one clock using the current inputs
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit tf, fl, gt, snd, rcv;
         int cnt;
         model_gate(k, tf, fl, gt);
         snd = req_valid && gt && cache_ready;
         rcv = rsp_valid && mbusy[k][rsp_tag];
         cnt = mcount(k);
         if (rsp_valid && !mbusy[k][rsp_tag]) merr[k] = 1'b1;
         case (mstate[k])
            0:       if (fence) mstate[k] = 1;
            1:       if (cnt == 0 && wbuf_empty && !rcv) mstate[k] = 2;
            default: mstate[k] = 0;
         endcase
         if (rcv) mbusy[k][rsp_tag] = 1'b0;
         if (snd) mbusy[k][req_tag] = 1'b1;
      end
   endtask

   // one cycle: inputs already driven at posedge+1
   task automatic step();
      #2;
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit rv, input int rt, input bit cr, input bit sv,
                         input int st, input bit wb, input bit fn);
      req_valid   = rv;
      req_tag     = TAG_W'(rt);
      cache_ready = cr;
      rsp_valid   = sv;
      rsp_tag     = TAG_W'(st);
      wbuf_empty  = wb;
      fence       = fn;
   endtask

   task automatic do_reset();
      set_in(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check("rst.a.inflight", int'(a_inflight), 0);
      check("rst.b.inflight", int'(b_inflight), 0);
      check("rst.a.err",      int'(a_err), 0);
      check("rst.b.err",      int'(b_err), 0);
      check("rst.a.busy",     int'(a_fence_busy), 0);
      check("rst.b.busy",     int'(b_fence_busy), 0);
      check("rst.a.req_valid", int'(a_req_valid), 0);
      check("rst.b.req_ready", int'(b_req_ready), 0);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NT; i++) mbusy[k][i] = 1'b0;
         mstate[k] = 0;
         merr[k]   = 1'b0;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // 1: duplicate tag blocked until its response returns
      set_in(1'b1, 5, 1'b1, 1'b0, 0, 1'b1, 1'b0); step();
      check("s1.inflight", int'(b_inflight), 1);
      set_in(1'b1, 5, 1'b1, 1'b0, 0, 1'b1, 1'b0); step();
      set_in(1'b0, 5, 1'b1, 1'b1, 5, 1'b1, 1'b0); step();
      set_in(1'b1, 5, 1'b1, 1'b0, 0, 1'b1, 1'b0); step();
      check("s1.reissue", int'(b_inflight), 1);
      do_reset();

      // 2: same-cycle response and request on a busy tag (bypass on dut_a)
      set_in(1'b1, 9, 1'b1, 1'b0, 0, 1'b1, 1'b0); step();
      set_in(1'b1, 9, 1'b1, 1'b1, 9, 1'b1, 1'b0); step();
      check("s2.a.inflight", int'(a_inflight), 1);
      check("s2.b.inflight", int'(b_inflight), 0);
      set_in(1'b1, 9, 1'b1, 1'b0, 0, 1'b1, 1'b0); step();
      do_reset();

      // 3: outstanding limit on dut_a
      for (int t = 0; t < 4; t++) begin
         set_in(1'b1, t, 1'b1, 1'b0, 0, 1'b1, 1'b0); step();
      end
      check("s3.full", int'(a_inflight), 4);
      set_in(1'b1, 4, 1'b1, 1'b0, 0, 1'b1, 1'b0); step();
      set_in(1'b1, 4, 1'b1, 1'b1, 2, 1'b1, 1'b0); step();
      set_in(1'b1, 4, 1'b1, 1'b0, 0, 1'b1, 1'b0); step();
      check("s3.after", int'(a_inflight), 4);
      do_reset();

      // 4: fence drains outstanding work and the write buffer
      for (int t = 1; t < 4; t++) begin
         set_in(1'b1, t, 1'b1, 1'b0, 0, 1'b0, 1'b0); step();
      end
      set_in(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1); step();
      check("s4.a.fence_busy", int'(a_fence_busy), 1);
      for (int t = 1; t < 4; t++) begin
         set_in(1'b1, 7, 1'b1, 1'b1, t, 1'b0, 1'b0); step();
      end
      set_in(1'b1, 7, 1'b1, 1'b0, 0, 1'b0, 1'b0); step();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 7, 1'b1, 1'b0, 0, 1'b1, 1'b0); step();
      end
      check("s4.b.after", int'(b_inflight), 1);

      // 5: spurious response is sticky until reset
      do_reset();
      set_in(1'b0, 0, 1'b1, 1'b1, 40, 1'b1, 1'b0); step();
      check("s5.err", int'(b_err), 1);
      set_in(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0); step(); step();
      do_reset();

      // 6: reset while draining with 7 busy tags
      for (int t = 10; t < 17; t++) begin
         set_in(1'b1, t, 1'b1, 1'b0, 0, 1'b0, 1'b0); step();
      end
      set_in(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1); step();
      check("s6.b.pre", int'(b_inflight), 7);
      do_reset();
      set_in(1'b1, 10, 1'b1, 1'b0, 0, 1'b0, 1'b0); step();
      check("s6.b.reissue", int'(b_inflight), 1);

      // random traffic with periodic resets
      for (int blk = 0; blk < 4; blk++) begin
         do_reset();
         for (int c = 0; c < 600; c++) begin
            req_valid   = ($urandom_range(0, 9) < 7);
            req_tag     = ($urandom_range(0, 9) < 9) ? TAG_W'($urandom_range(0, 15))
                                                     : TAG_W'($urandom_range(0, NT - 1));
            cache_ready = ($urandom_range(0, 9) < 8);
            rsp_valid   = ($urandom_range(0, 9) < 4);
            rsp_tag     = ($urandom_range(0, 99) < 97) ? TAG_W'($urandom_range(0, 15))
                                                       : TAG_W'($urandom_range(0, NT - 1));
            wbuf_empty  = ($urandom_range(0, 9) < 7);
            fence       = ($urandom_range(0, 99) < 3);
            step();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
